// File: rtl/rb_pkg.sv
// Shared definitions for the read-back engine: FSM state encoding, default
// geometry (address width is common with the write-back block) and a helper
// that sizes burst index fields.
package rb_pkg;

    localparam int RB_DATA_W = 32;
    localparam int RB_ADDR_W = 4;
    localparam int RB_BURST  = 4;

    typedef enum logic [1:0] {
        RB_IDLE  = 2'd0,
        RB_FETCH = 2'd1,
        RB_DRAIN = 2'd2
    } rb_state_e;

    // Width of an index into a burst; never less than one bit.
    function automatic int rb_idx_w(input int burst);
        return (burst > 1) ? $clog2(burst) : 1;
    endfunction

endpackage

// File: rtl/rb_if.sv
// Output stream of the read-back engine: one burst word per valid/ready
// transfer, tagged with its index in the burst and a last flag.
interface rb_if
    import rb_pkg::*;
#(
    parameter int DATA_W = RB_DATA_W,
    parameter int IDX_W  = rb_idx_w(RB_BURST)
);

    logic              valid;
    logic              ready;
    logic [DATA_W-1:0] data;
    logic [IDX_W-1:0]  idx;
    logic              last;

    modport master (output valid, data, idx, last, input ready);
    modport slave  (input valid, data, idx, last, output ready);

endinterface

// File: rtl/rb_buf.sv
// Burst capture buffer: one synchronous write port, one combinational read
// port, contents cleared by the asynchronous reset.
module rb_buf
    import rb_pkg::*;
#(
    parameter int DEPTH  = RB_BURST,
    parameter int DATA_W = RB_DATA_W,
    parameter int IDX_W  = rb_idx_w(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [IDX_W-1:0]  wr_idx,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [IDX_W-1:0]  rd_idx,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];

    // Next buffer contents: hold, or overwrite the addressed entry.
    always_comb begin
        // NOTE: default the whole array first so no path leaves mem_d unassigned (no latch).
        mem_d = mem_q;
        if (wr_en) begin
            mem_d[wr_idx] = wr_data;
        end
    end

    // Buffer storage with asynchronous clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            // NOTE: the buffer is reset on purpose so a burst abandoned by reset leaves no stale words behind.
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            // NOTE: non-blocking so every flop samples pre-edge values.
            mem_q <= mem_d;
        end
    end

    assign rd_data = mem_q[rd_idx];

endmodule

// File: rtl/rb.sv
// Read-back engine. A start pulse in IDLE issues BURST sequential reads from
// the result RAM (latency-1 registered RAM), captures the words into rb_buf,
// then streams them out on the valid/ready port.
// Optional feature: define RB_CHECKSUM_EN to add the checksum output, the
// unsigned sum of the captured burst.
module rb
    import rb_pkg::*;
#(
    parameter  int DATA_W = RB_DATA_W,
    parameter  int ADDR_W = RB_ADDR_W,
    parameter  int BURST  = RB_BURST,
    localparam int IDX_W  = rb_idx_w(BURST),
    localparam int CNT_W  = $clog2(BURST) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    output logic              ram_en,
    output logic [ADDR_W-1:0] ram_addr,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic              busy,
`ifdef RB_CHECKSUM_EN
    output logic [DATA_W+IDX_W-1:0] checksum,
`endif
    rb_if.master              out_if
);

    rb_state_e         state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [CNT_W-1:0]  issue_cnt_q, issue_cnt_d;
    logic [CNT_W-1:0]  cap_cnt_q, cap_cnt_d;
    logic [CNT_W-1:0]  drain_cnt_q, drain_cnt_d;
    logic              ram_en_q, ram_en_d;
    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic              rd_vld_q, rd_vld_d;
    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic [IDX_W-1:0]  out_idx_q, out_idx_d;
    logic              out_last_q, out_last_d;

    logic              wr_en;
    logic [IDX_W-1:0]  wr_idx;
    logic [IDX_W-1:0]  rd_idx;
    logic [DATA_W-1:0] rd_data;

`ifdef RB_CHECKSUM_EN
    localparam int SUM_W = DATA_W + IDX_W;
    logic [SUM_W-1:0] sum_q, sum_d;
`endif

    rb_buf #(
        .DEPTH  (BURST),
        .DATA_W (DATA_W),
        .IDX_W  (IDX_W)
    ) u_buf (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en),
        .wr_idx  (wr_idx),
        .wr_data (ram_rdata),
        .rd_idx  (rd_idx),
        .rd_data (rd_data)
    );

    // FSM next state: issue reads, capture returning data, drain the buffer.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        issue_cnt_d = issue_cnt_q;
        cap_cnt_d   = cap_cnt_q;
        drain_cnt_d = drain_cnt_q;
        ram_en_d    = 1'b0;
        ram_addr_d  = ram_addr_q;
        // RAM data is valid the cycle after its read was issued.
        rd_vld_d    = ram_en_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_idx_d   = out_idx_q;
        out_last_d  = out_last_q;
        wr_en       = 1'b0;
        wr_idx      = cap_cnt_q[IDX_W-1:0];
        rd_idx      = '0;
`ifdef RB_CHECKSUM_EN
        sum_d       = sum_q;
`endif

        case (state_q)
            RB_IDLE: begin
                if (start) begin
                    state_d     = RB_FETCH;
                    addr_d      = base_addr;
                    // The first read goes out on the transition itself.
                    issue_cnt_d = CNT_W'(1);
                    cap_cnt_d   = '0;
                    drain_cnt_d = '0;
                    ram_en_d    = 1'b1;
                    ram_addr_d  = base_addr;
`ifdef RB_CHECKSUM_EN
                    sum_d       = '0;
`endif
                end
            end

            RB_FETCH: begin
                if (issue_cnt_q < CNT_W'(BURST)) begin
                    ram_en_d    = 1'b1;
                    ram_addr_d  = addr_q + ADDR_W'(issue_cnt_q);
                    issue_cnt_d = issue_cnt_q + 1'b1;
                end
                if (rd_vld_q) begin
                    wr_en     = 1'b1;
                    cap_cnt_d = cap_cnt_q + 1'b1;
`ifdef RB_CHECKSUM_EN
                    sum_d     = sum_q + SUM_W'(ram_rdata);
`endif
                    if (cap_cnt_q == CNT_W'(BURST - 1)) begin
                        state_d     = RB_DRAIN;
                        out_valid_d = 1'b1;
                        out_idx_d   = '0;
                        out_last_d  = (BURST == 1);
                        // Word 0 may be the one being written this edge.
                        out_data_d  = (wr_idx == rd_idx) ? ram_rdata : rd_data;
                    end
                end
            end

            RB_DRAIN: begin
                rd_idx = IDX_W'(drain_cnt_q + 1'b1);
                if (out_if.ready) begin
                    if (out_last_q) begin
                        state_d     = RB_IDLE;
                        out_valid_d = 1'b0;
                        out_data_d  = '0;
                        out_idx_d   = '0;
                        out_last_d  = 1'b0;
                        drain_cnt_d = '0;
                    end else begin
                        drain_cnt_d = drain_cnt_q + 1'b1;
                        out_idx_d   = rd_idx;
                        out_data_d  = rd_data;
                        out_last_d  = (drain_cnt_d == CNT_W'(BURST - 1));
                    end
                end
            end

            default: begin
                state_d = RB_IDLE;
            end
        endcase
    end

    // FSM and registered outputs, all cleared by reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= RB_IDLE;
            addr_q      <= '0;
            issue_cnt_q <= '0;
            cap_cnt_q   <= '0;
            drain_cnt_q <= '0;
            ram_en_q    <= 1'b0;
            ram_addr_q  <= '0;
            rd_vld_q    <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_idx_q   <= '0;
            out_last_q  <= 1'b0;
`ifdef RB_CHECKSUM_EN
            sum_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            issue_cnt_q <= issue_cnt_d;
            cap_cnt_q   <= cap_cnt_d;
            drain_cnt_q <= drain_cnt_d;
            ram_en_q    <= ram_en_d;
            ram_addr_q  <= ram_addr_d;
            rd_vld_q    <= rd_vld_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_idx_q   <= out_idx_d;
            out_last_q  <= out_last_d;
`ifdef RB_CHECKSUM_EN
            sum_q       <= sum_d;
`endif
        end
    end

    assign busy         = (state_q != RB_IDLE);
    assign ram_en       = ram_en_q;
    assign ram_addr     = ram_addr_q;
    assign out_if.valid = out_valid_q;
    assign out_if.data  = out_data_q;
    assign out_if.idx   = out_idx_q;
    assign out_if.last  = out_last_q;
`ifdef RB_CHECKSUM_EN
    assign checksum     = sum_q;
`endif

endmodule

// File: tb/tb_rb.sv
// Bench for the read-back engine: latency-1 RAM model preloaded with
// 0x1000+i, a table of bursts with hand-computed addresses/data/cycle counts,
// plus sequences for ignored start pulses, mid-burst reset and (when
// RB_CHECKSUM_EN is defined) the checksum output.
module tb_rb;
    import rb_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [3:0]  base_addr = '0;
    logic        ram_en;
    logic [3:0]  ram_addr;
    logic [31:0] ram_rdata = '0;
    logic        busy;
    logic        out_ready = 1'b0;
    logic        out_valid;
    logic [31:0] out_data;
    logic [1:0]  out_idx;
    logic        out_last;
`ifdef RB_CHECKSUM_EN
    logic [33:0] checksum;
`endif

    rb_if #(.DATA_W(32), .IDX_W(2)) out_if ();

    assign out_if.ready = out_ready;
    assign out_valid    = out_if.valid;
    assign out_data     = out_if.data;
    assign out_idx      = out_if.idx;
    assign out_last     = out_if.last;

    rb dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .base_addr (base_addr),
        .ram_en    (ram_en),
        .ram_addr  (ram_addr),
        .ram_rdata (ram_rdata),
        .busy      (busy),
`ifdef RB_CHECKSUM_EN
        .checksum  (checksum),
`endif
        .out_if    (out_if)
    );

    always #5 clk = ~clk;

    // Registered RAM, one cycle of read latency.
    logic [31:0] mem [16];
    always @(posedge clk) begin
        if (ram_en) ram_rdata <= mem[ram_addr];
    end

    // Log of issued read addresses and accepted output words.
    int          n_iss = 0;
    int          n_acc = 0;
    logic [3:0]  addr_log [256];
    logic [31:0] acc_data [256];
    logic [1:0]  acc_idx  [256];
    logic        acc_last [256];
    always @(posedge clk) begin
        if (rst && ram_en) begin
            addr_log[n_iss] <= ram_addr;
            n_iss           <= n_iss + 1;
        end
        if (rst && out_valid && out_ready) begin
            acc_data[n_acc] <= out_data;
            acc_idx[n_acc]  <= out_idx;
            acc_last[n_acc] <= out_last;
            n_acc           <= n_acc + 1;
        end
    end

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    typedef struct packed {
        logic [3:0]        base;
        logic [15:0]       rdy;       // bit k = out_ready in the k-th valid cycle
        logic [3:0][3:0]   exp_addr;
        logic [3:0][31:0]  exp_data;
        logic [7:0]        exp_cyc;   // cycles with busy high
        logic [33:0]       exp_sum;
    } vec_t;

    // One burst: pulse start, follow the ready pattern, check everything.
    // poke re-asserts start during FETCH and on the cycle out_last is accepted.
    task automatic run_burst(input vec_t v, input bit poke, input string tag);
        int          cyc;
        int          k;
        int          first_v;
        int          i0;
        int          a0;
        logic        pv;
        logic        pr;
        logic [31:0] pd;
        logic [1:0]  pi;
        i0 = n_iss; a0 = n_acc;
        cyc = 0; k = 0; first_v = 0; pv = 1'b0; pr = 1'b0; pd = '0; pi = '0;
        @(negedge clk);
        start = 1'b1; base_addr = v.base; out_ready = 1'b0;
        while (cyc < 100) begin
            @(negedge clk);
            if (pv && !pr) begin
                check($sformatf("%s_stall_data", tag), out_data, pd);
                check($sformatf("%s_stall_idx", tag), out_idx, pi);
            end
            if (!busy) break;
            cyc++;
            start     = poke && (cyc == 2 || (out_valid && out_last));
            base_addr = 4'd9;
            if (out_valid) begin
                if (first_v == 0) first_v = cyc;
`ifdef RB_CHECKSUM_EN
                check($sformatf("%s_checksum", tag), checksum, v.exp_sum);
`endif
                out_ready = (k < 16) ? v.rdy[k] : 1'b1;
                k++;
            end else begin
                out_ready = 1'b0;
            end
            pv = out_valid; pr = out_ready; pd = out_data; pi = out_idx;
        end
        start = 1'b0;
        check($sformatf("%s_busy_low", tag), busy, 0);
        check($sformatf("%s_busy_cycles", tag), cyc, v.exp_cyc);
        check($sformatf("%s_first_valid", tag), first_v, 6);
        repeat (3) @(negedge clk);
        check($sformatf("%s_n_issue", tag), n_iss - i0, 4);
        for (int i = 0; i < 4; i++)
            check($sformatf("%s_addr%0d", tag, i), addr_log[i0 + i], v.exp_addr[i]);
        check($sformatf("%s_n_accept", tag), n_acc - a0, 4);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("%s_data%0d", tag, i), acc_data[a0 + i], v.exp_data[i]);
            check($sformatf("%s_idx%0d", tag, i), acc_idx[a0 + i], i);
            check($sformatf("%s_last%0d", tag, i), acc_last[a0 + i], (i == 3));
        end
    endtask

    task automatic check_all_zero(input string tag);
        check($sformatf("%s_busy", tag), busy, 0);
        check($sformatf("%s_ram_en", tag), ram_en, 0);
        check($sformatf("%s_ram_addr", tag), ram_addr, 0);
        check($sformatf("%s_out_valid", tag), out_valid, 0);
        check($sformatf("%s_out_data", tag), out_data, 0);
        check($sformatf("%s_out_idx", tag), out_idx, 0);
        check($sformatf("%s_out_last", tag), out_last, 0);
`ifdef RB_CHECKSUM_EN
        check($sformatf("%s_checksum", tag), checksum, 0);
`endif
    endtask

    vec_t vecs [3];
    vec_t v_poke;
    vec_t v_zero;
`ifdef RB_CHECKSUM_EN
    vec_t v_sum;
`endif

    initial begin
        bit found;
        int a_r;

        for (int i = 0; i < 16; i++) mem[i] = 32'h1000 + i;

        vecs[0] = '{base: 4'd2, rdy: 16'hFFFF,
                    exp_addr: {4'd5, 4'd4, 4'd3, 4'd2},
                    exp_data: {32'h1005, 32'h1004, 32'h1003, 32'h1002},
                    exp_cyc: 8'd9, exp_sum: 34'h400E};
        vecs[1] = '{base: 4'd14, rdy: 16'hFFFF,
                    exp_addr: {4'd1, 4'd0, 4'd15, 4'd14},
                    exp_data: {32'h1001, 32'h1000, 32'h100F, 32'h100E},
                    exp_cyc: 8'd9, exp_sum: 34'h401E};
        // ready 1,0,0,1,0,1,1 over the valid cycles: three stalls.
        vecs[2] = '{base: 4'd7, rdy: 16'hFFE9,
                    exp_addr: {4'd10, 4'd9, 4'd8, 4'd7},
                    exp_data: {32'h100A, 32'h1009, 32'h1008, 32'h1007},
                    exp_cyc: 8'd12, exp_sum: 34'h4022};
        v_poke  = '{base: 4'd5, rdy: 16'hFFFF,
                    exp_addr: {4'd8, 4'd7, 4'd6, 4'd5},
                    exp_data: {32'h1008, 32'h1007, 32'h1006, 32'h1005},
                    exp_cyc: 8'd9, exp_sum: 34'h401A};
        v_zero  = '{base: 4'd0, rdy: 16'hFFFF,
                    exp_addr: {4'd3, 4'd2, 4'd1, 4'd0},
                    exp_data: {32'h1003, 32'h1002, 32'h1001, 32'h1000},
                    exp_cyc: 8'd9, exp_sum: 34'h4006};

        // Reset state.
        #2 rst = 1'b0;
        #1 check_all_zero("reset");
        repeat (2) @(negedge clk);
        rst = 1'b1;

        for (int t = 0; t < 3; t++) run_burst(vecs[t], 1'b0, $sformatf("vec%0d", t));

        run_burst(v_poke, 1'b1, "poke");

        // Reset while drain_cnt = 2.
        @(negedge clk);
        start = 1'b1; base_addr = 4'd2; out_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 30 && !found; c++) begin
            if (out_valid && out_idx == 2'd2) found = 1'b1;
            else @(negedge clk);
        end
        check("mid_rst_reached_idx2", found, 1);
        a_r = n_acc;
        rst = 1'b0;
        #1 check_all_zero("mid_rst");
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("post_rst_out_valid", out_valid, 0);
        check("post_rst_no_accept", n_acc - a_r, 0);
        run_burst(v_zero, 1'b0, "after_rst");

`ifdef RB_CHECKSUM_EN
        for (int i = 8; i < 12; i++) mem[i] = 32'hFFFF_FFFF;
        v_sum = '{base: 4'd8, rdy: 16'hFFFF,
                  exp_addr: {4'd11, 4'd10, 4'd9, 4'd8},
                  exp_data: {32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF},
                  exp_cyc: 8'd9, exp_sum: 34'h3_FFFF_FFFC};
        run_burst(v_sum, 1'b0, "sum_max");
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", n_pass, n_chk);
        $fatal(1, "watchdog");
    end

endmodule
